// File: rtl/sync_fifo_vr_pkg.sv
// Shared definitions for the sync_fifo_vr streaming FIFO: default sizing,
// a status bundle for monitors/scoreboards and the pointer wrap helper.
package sync_fifo_pkg;

    localparam int DEFAULT_DEPTH   = 32;
    localparam int DEFAULT_OUT_REG = 0;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_status_t;

    // Advance a pointer and wrap it explicitly at the last slot, so depths
    // that are not a power of two never index past the array.
    function automatic int wrapInc(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_vr_if.sv
// Valid/ready handshake bundle for sync_fifo_vr: write side (s_*) and
// read side (m_*). The FIFO uses the slave view; the surrounding logic
// (producer and consumer together) uses the master view.
interface sync_fifo_vr_if #(
    parameter type DTYPE = logic [7:0]
);
    logic s_valid;
    logic s_ready;
    DTYPE s_data;
    logic m_valid;
    logic m_ready;
    DTYPE m_data;

    modport slave (
        input  s_valid,
        input  s_data,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_data
    );

    modport master (
        output s_valid,
        output s_data,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/sync_fifo_out_stage.sv
// Registered output stage for sync_fifo_vr. Holds the head word in a flop
// so m_data/m_valid come straight from registers. It refills whenever it is
// empty or being popped and the memory behind it has a word available.
module sync_fifo_out_stage #(
    parameter type DTYPE = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic i_memAvail,
    input  DTYPE i_memData,
    input  logic i_ready,
    output logic o_load,
    output logic o_valid,
    output DTYPE o_data
);

    logic r_valid;
    DTYPE r_data;

    // A load consumes the memory head; the parent advances its read pointer on it.
    assign o_load  = (!r_valid || i_ready) && i_memAvail && !flush;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Valid flag: set on a load, cleared when popped with nothing behind it or on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (o_load) begin
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload register; its contents are meaningless while r_valid is low.
    always_ff @(posedge clk) begin
        if (o_load) begin
            r_data <= i_memData;
        end
    end

endmodule

// File: rtl/sync_fifo_vr.sv
// sync_fifo_vr: single-clock valid/ready FIFO with arbitrary depth,
// programmable almost-full/almost-empty flags, synchronous flush and an
// optional registered output stage (OUT_REG = 1).
// Optional feature macro: SYNC_FIFO_WMARK_EN adds wmark_clr / max_count,
// a peak-occupancy watermark.
module sync_fifo_vr
    import sync_fifo_pkg::*;
#(
    parameter type DTYPE      = logic [7:0],
    parameter int  FIFO_DEPTH = DEFAULT_DEPTH,
    parameter int  ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int  OUT_REG    = DEFAULT_OUT_REG
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    sync_fifo_vr_if.slave         bus,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty
`ifdef SYNC_FIFO_WMARK_EN
    ,
    input  logic                  wmark_clr,
    output logic [ADDR_WIDTH:0]   max_count
`endif
);

    localparam int                CW        = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    DTYPE                  r_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wrPtr;
    logic [ADDR_WIDTH-1:0] r_rdPtr;
    logic [ADDR_WIDTH:0]   r_count;

    fifo_status_t w_status;
    logic         w_push;
    logic         w_pop;
    logic         w_memRead;
    logic         w_mValid;
    DTYPE         w_mData;
    DTYPE         w_memData;

    // Status decoded from the registered count; thresholds act immediately.
    always_comb begin
        w_status              = '0;
        w_status.empty        = (r_count == '0);
        w_status.full         = (r_count == DEPTH_CNT);
        w_status.almost_empty = (r_count <= ae_thresh);
        w_status.almost_full  = (r_count >= af_thresh);
    end

    // s_ready depends only on state, never on m_ready, so a full FIFO
    // refuses a write even when a pop happens in the same cycle.
    assign bus.s_ready  = !w_status.full;
    assign w_push       = bus.s_valid && !w_status.full;
    assign w_pop        = w_mValid && bus.m_ready;
    assign bus.m_valid  = w_mValid;
    assign bus.m_data   = w_mData;
    assign w_memData    = r_mem[r_rdPtr];

    assign count        = r_count;
    assign almost_full  = w_status.almost_full;
    assign almost_empty = w_status.almost_empty;

    generate
        if (OUT_REG != 0) begin : g_outReg
            logic w_oValid;
            logic w_load;
            logic w_memAvail;

            // count includes the output register, so memory holds count - ovalid words.
            assign w_memAvail = (r_count > CW'(w_oValid));

            sync_fifo_out_stage #(
                .DTYPE (DTYPE)
            ) u_outStage (
                .clk        (clk),
                .rst_n      (rst_n),
                .flush      (flush),
                .i_memAvail (w_memAvail),
                .i_memData  (w_memData),
                .i_ready    (bus.m_ready),
                .o_load     (w_load),
                .o_valid    (w_oValid),
                .o_data     (w_mData)
            );

            assign w_memRead = w_load;
            assign w_mValid  = w_oValid;
        end else begin : g_combOut
            assign w_memRead = w_pop;
            assign w_mValid  = !w_status.empty;
            assign w_mData   = w_memData;
        end
    endgenerate

    // Storage write; a push in a flush cycle is discarded.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wrPtr] <= bus.s_data;
        end
    end

    // Pointers and occupancy; flush takes priority over any push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= ADDR_WIDTH'(wrapInc(int'(r_wrPtr), FIFO_DEPTH));
            end
            if (w_memRead) begin
                r_rdPtr <= ADDR_WIDTH'(wrapInc(int'(r_rdPtr), FIFO_DEPTH));
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push && !w_status.empty) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

`ifdef SYNC_FIFO_WMARK_EN
    logic [ADDR_WIDTH:0] r_maxCount;

    // Peak occupancy, trailing count by one cycle; clear/flush restart it at the current count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_maxCount <= '0;
        end else if (flush || wmark_clr) begin
            r_maxCount <= r_count;
        end else if (r_count > r_maxCount) begin
            r_maxCount <= r_count;
        end
    end

    assign max_count = r_maxCount;
`endif

endmodule

// File: tb/tb_sync_fifo_vr.sv
// Testbench for sync_fifo_vr: two depth-5 instances (OUT_REG = 0 and 1)
// share stimulus; each is checked every cycle against a queue model in
// which a word becomes visible a fixed number of cycles after its push.
module tb_sync_fifo_vr;

    localparam int DEPTH = 5;
    localparam int AW    = $clog2(DEPTH);
    localparam int QN    = 256;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          sValid;
    logic [7:0]    sData;
    logic          mReady;
    logic [AW:0]   afThresh;
    logic [AW:0]   aeThresh;
    logic [AW:0]   count0, count1;
    logic          af0, af1, ae0, ae1;
`ifdef SYNC_FIFO_WMARK_EN
    logic          wmarkClr;
    logic [AW:0]   maxCount0, maxCount1;
`endif

    int checks;
    int errors;
    int cyc;

    // Reference model: circular queue per instance with push timestamps.
    logic [7:0] mData  [2][QN];
    int         mStamp [2][QN];
    int         mHead  [2];
    int         mSize  [2];
    int         maxExp [2];
    int         popCnt [2];
    logic [7:0] lastPop[2];

    sync_fifo_vr_if #(.DTYPE(logic [7:0])) bus0 ();
    sync_fifo_vr_if #(.DTYPE(logic [7:0])) bus1 ();

    assign bus0.s_valid = sValid;
    assign bus0.s_data  = sData;
    assign bus0.m_ready = mReady;
    assign bus1.s_valid = sValid;
    assign bus1.s_data  = sData;
    assign bus1.m_ready = mReady;

    sync_fifo_vr #(.DTYPE(logic [7:0]), .FIFO_DEPTH(DEPTH), .OUT_REG(0)) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus0),
        .af_thresh    (afThresh),
        .ae_thresh    (aeThresh),
        .count        (count0),
        .almost_full  (af0),
        .almost_empty (ae0)
`ifdef SYNC_FIFO_WMARK_EN
        ,
        .wmark_clr    (wmarkClr),
        .max_count    (maxCount0)
`endif
    );

    sync_fifo_vr #(.DTYPE(logic [7:0]), .FIFO_DEPTH(DEPTH), .OUT_REG(1)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus1),
        .af_thresh    (afThresh),
        .ae_thresh    (aeThresh),
        .count        (count1),
        .almost_full  (af1),
        .almost_empty (ae1)
`ifdef SYNC_FIFO_WMARK_EN
        ,
        .wmark_clr    (wmarkClr),
        .max_count    (maxCount1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: compare both instances before the edge, then advance the model.
    task automatic tick();
        logic       willPush [2];
        logic       willPop  [2];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic       oReady, oValid, oAf, oAe;
            logic [7:0] oData;
            int         oCount;
            logic       eReady, eValid;
            oReady = (k == 0) ? bus0.s_ready : bus1.s_ready;
            oValid = (k == 0) ? bus0.m_valid : bus1.m_valid;
            oData  = (k == 0) ? bus0.m_data  : bus1.m_data;
            oCount = (k == 0) ? int'(count0) : int'(count1);
            oAf    = (k == 0) ? af0 : af1;
            oAe    = (k == 0) ? ae0 : ae1;
            eReady = (mSize[k] != DEPTH);
            eValid = 1'b0;
            if (mSize[k] != 0) begin
                eValid = ((cyc - mStamp[k][mHead[k]]) >= k);
            end
            checks++;
            if (oReady !== eReady) begin
                errors++;
                $display("[TB] FAIL s_ready[%0d] cyc %0d: got %0b want %0b", k, cyc, oReady, eReady);
            end
            checks++;
            if (oValid !== eValid) begin
                errors++;
                $display("[TB] FAIL m_valid[%0d] cyc %0d: got %0b want %0b", k, cyc, oValid, eValid);
            end
            if (eValid) begin
                checks++;
                if (oData !== mData[k][mHead[k]]) begin
                    errors++;
                    $display("[TB] FAIL m_data[%0d] cyc %0d: got %02h want %02h", k, cyc, oData, mData[k][mHead[k]]);
                end
            end
            checks++;
            if (oCount != mSize[k]) begin
                errors++;
                $display("[TB] FAIL count[%0d] cyc %0d: got %0d want %0d", k, cyc, oCount, mSize[k]);
            end
            checks++;
            if (oAf !== (mSize[k] >= int'(afThresh))) begin
                errors++;
                $display("[TB] FAIL almost_full[%0d] cyc %0d: got %0b want %0b", k, cyc, oAf, (mSize[k] >= int'(afThresh)));
            end
            checks++;
            if (oAe !== (mSize[k] <= int'(aeThresh))) begin
                errors++;
                $display("[TB] FAIL almost_empty[%0d] cyc %0d: got %0b want %0b", k, cyc, oAe, (mSize[k] <= int'(aeThresh)));
            end
`ifdef SYNC_FIFO_WMARK_EN
            checks++;
            if (((k == 0) ? int'(maxCount0) : int'(maxCount1)) != maxExp[k]) begin
                errors++;
                $display("[TB] FAIL max_count[%0d] cyc %0d: got %0d want %0d", k, cyc,
                         ((k == 0) ? int'(maxCount0) : int'(maxCount1)), maxExp[k]);
            end
`endif
            willPush[k] = sValid && eReady;
            willPop[k]  = eValid && mReady;
        end
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            int prior;
            prior = mSize[k];
            if (flush) begin
                mSize[k] = 0;
                mHead[k] = 0;
            end else begin
                if (willPop[k]) begin
                    lastPop[k] = mData[k][mHead[k]];
                    popCnt[k]++;
                    mHead[k] = (mHead[k] + 1) % QN;
                    mSize[k]--;
                end
                if (willPush[k]) begin
                    mData[k][(mHead[k] + mSize[k]) % QN]  = sData;
                    mStamp[k][(mHead[k] + mSize[k]) % QN] = cyc;
                    mSize[k]++;
                end
            end
`ifdef SYNC_FIFO_WMARK_EN
            if (flush || wmarkClr) maxExp[k] = prior;
            else if (prior > maxExp[k]) maxExp[k] = prior;
`else
            if (prior > maxExp[k]) maxExp[k] = prior;
`endif
        end
        #1;
    endtask

    task automatic idleInputs();
        sValid = 1'b0;
        mReady = 1'b0;
        flush  = 1'b0;
`ifdef SYNC_FIFO_WMARK_EN
        wmarkClr = 1'b0;
`endif
    endtask

    task automatic doFlush();
        idleInputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst_n    = 1'b0;
        idleInputs();
        sData    = 8'h00;
        afThresh = '0;
        aeThresh = '0;
        #12;
        checks++;
        if (bus0.s_ready !== 1'b1 || bus1.s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_s_ready: got %0b/%0b want 1/1", bus0.s_ready, bus1.s_ready);
        end
        checks++;
        if (bus0.m_valid !== 1'b0 || bus1.m_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_m_valid: got %0b/%0b want 0/0", bus0.m_valid, bus1.m_valid);
        end
        checks++;
        if (count0 !== '0 || count1 !== '0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d/%0d want 0/0", count0, count1);
        end
        checks++;
        if (ae0 !== 1'b1 || ae1 !== 1'b1 || af0 !== 1'b1 || af1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_flags_af0: ae %0b/%0b af %0b/%0b want all 1", ae0, ae1, af0, af1);
        end
        afThresh = 4'd3;
        #1;
        checks++;
        if (af0 !== 1'b0 || af1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_af_thresh3: got %0b/%0b want 0/0", af0, af1);
        end
`ifdef SYNC_FIFO_WMARK_EN
        checks++;
        if (maxCount0 !== '0 || maxCount1 !== '0) begin
            errors++;
            $display("[TB] FAIL reset_max_count: got %0d/%0d want 0/0", maxCount0, maxCount1);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_drain();
        $display("[TB] test_fill_drain");
        afThresh = 4'd5;
        aeThresh = 4'd0;
        doFlush();
        for (int i = 0; i < 5; i++) begin
            sValid = 1'b1;
            sData  = 8'(8'h10 + i);
            tick();
        end
        sValid = 1'b0;
        checks++;
        if (bus0.s_ready !== 1'b0 || count0 !== 4'd5) begin
            errors++;
            $display("[TB] FAIL fill_full: s_ready %0b count %0d want 0 and 5", bus0.s_ready, count0);
        end
        mReady = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (count0 !== '0 || count1 !== '0 || lastPop[0] !== 8'h14 || lastPop[1] !== 8'h14) begin
            errors++;
            $display("[TB] FAIL drain_end: count %0d/%0d last %02h/%02h want 0/0 14/14",
                     count0, count1, lastPop[0], lastPop[1]);
        end
        mReady = 1'b0;
    endtask

    task automatic test_back_to_back();
        int p0, p1;
        $display("[TB] test_back_to_back");
        doFlush();
        p0 = popCnt[0];
        p1 = popCnt[1];
        sValid = 1'b1;
        mReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sData = 8'(8'h40 + i);
            tick();
        end
        idleInputs();
        checks++;
        if (popCnt[0] - p0 != 19 || popCnt[1] - p1 != 18) begin
            errors++;
            $display("[TB] FAIL b2b_pops: got %0d/%0d want 19/18", popCnt[0] - p0, popCnt[1] - p1);
        end
        for (int i = 0; i < 3; i++) begin
            mReady = 1'b1;
            tick();
        end
        mReady = 1'b0;
    endtask

    task automatic test_full_push_pop();
        $display("[TB] test_full_push_pop");
        doFlush();
        sValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sData = 8'(8'h60 + i);
            tick();
        end
        tick();
        sData  = 8'hEE;
        mReady = 1'b1;
        tick();
        idleInputs();
        checks++;
        if (count0 !== 4'd4 || count1 !== 4'd4 || bus0.s_ready !== 1'b1 || bus1.s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_push_pop: count %0d/%0d s_ready %0b/%0b want 4/4 1/1",
                     count0, count1, bus0.s_ready, bus1.s_ready);
        end
        tick();
    endtask

    task automatic test_thresholds();
        $display("[TB] test_thresholds");
        afThresh = 4'd3;
        aeThresh = 4'd1;
        doFlush();
        sValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sData = 8'(8'h30 + i);
            tick();
        end
        sValid = 1'b0;
        checks++;
        if (af0 !== 1'b1 || ae0 !== 1'b0 || af1 !== 1'b1 || ae1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL thresh_at3: af %0b/%0b ae %0b/%0b want 1/1 0/0", af0, af1, ae0, ae1);
        end
        afThresh = 4'd4;
        #1;
        checks++;
        if (af0 !== 1'b0 || af1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL thresh_change: af %0b/%0b want 0/0", af0, af1);
        end
        tick();
    endtask

    task automatic test_flush();
        int p1;
        $display("[TB] test_flush");
        doFlush();
        sValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sData = 8'(8'h20 + i);
            tick();
        end
        sValid = 1'b0;
        tick();
        tick();
        flush  = 1'b1;
        sValid = 1'b1;
        sData  = 8'h55;
        mReady = 1'b1;
        tick();
        idleInputs();
        checks++;
        if (count0 !== '0 || count1 !== '0 || bus0.m_valid !== 1'b0 || bus1.m_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_clear: count %0d/%0d m_valid %0b/%0b want 0/0 0/0",
                     count0, count1, bus0.m_valid, bus1.m_valid);
        end
        p1 = popCnt[1];
        sValid = 1'b1;
        sData  = 8'hAA;
        tick();
        sValid = 1'b0;
        mReady = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        mReady = 1'b0;
        checks++;
        if (popCnt[1] - p1 != 1 || lastPop[1] !== 8'hAA) begin
            errors++;
            $display("[TB] FAIL flush_first_word: pops %0d last %02h want 1 AA", popCnt[1] - p1, lastPop[1]);
        end
    endtask

`ifdef SYNC_FIFO_WMARK_EN
    task automatic test_wmark();
        $display("[TB] test_wmark");
        doFlush();
        wmarkClr = 1'b1;
        tick();
        wmarkClr = 1'b0;
        sValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sData = 8'(8'h70 + i);
            tick();
        end
        sValid = 1'b0;
        tick();
        mReady = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        mReady = 1'b0;
        checks++;
        if (maxCount0 !== 4'd4 || maxCount1 !== 4'd4 || count0 !== '0) begin
            errors++;
            $display("[TB] FAIL wmark_peak: max %0d/%0d count %0d want 4/4 0", maxCount0, maxCount1, count0);
        end
        wmarkClr = 1'b1;
        tick();
        wmarkClr = 1'b0;
        checks++;
        if (maxCount0 !== '0 || maxCount1 !== '0) begin
            errors++;
            $display("[TB] FAIL wmark_clr: max %0d/%0d want 0/0", maxCount0, maxCount1);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        $display("[TB] test_random");
        doFlush();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                afThresh = 4'($urandom_range(0, 6));
                aeThresh = 4'($urandom_range(0, 6));
            end
            sValid = 1'($urandom_range(0, 1));
            sData  = 8'($urandom);
            mReady = ($urandom_range(0, 9) < 7);
            flush  = ($urandom_range(0, 39) == 0);
`ifdef SYNC_FIFO_WMARK_EN
            wmarkClr = ($urandom_range(0, 29) == 0);
`endif
            tick();
        end
        idleInputs();
    endtask

    task automatic test_midreset();
        $display("[TB] test_midreset");
        afThresh = 4'd2;
        aeThresh = 4'd1;
        doFlush();
        sValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sData = 8'(8'h90 + i);
            tick();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (count0 !== '0 || count1 !== '0 || bus0.m_valid !== 1'b0 || bus1.m_valid !== 1'b0 ||
            bus0.s_ready !== 1'b1 || bus1.s_ready !== 1'b1 || ae0 !== 1'b1 || ae1 !== 1'b1 ||
            af0 !== 1'b0 || af1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: count %0d/%0d m_valid %0b/%0b s_ready %0b/%0b ae %0b/%0b af %0b/%0b",
                     count0, count1, bus0.m_valid, bus1.m_valid, bus0.s_ready, bus1.s_ready, ae0, ae1, af0, af1);
        end
`ifdef SYNC_FIFO_WMARK_EN
        checks++;
        if (maxCount0 !== '0 || maxCount1 !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_max_count: got %0d/%0d want 0/0", maxCount0, maxCount1);
        end
`endif
        for (int k = 0; k < 2; k++) begin
            mSize[k]  = 0;
            mHead[k]  = 0;
            maxExp[k] = 0;
        end
        @(posedge clk);
        @(negedge clk);
        idleInputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sValid = 1'b1;
        sData  = 8'hC3;
        tick();
        sValid = 1'b0;
        mReady = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        idleInputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        for (int k = 0; k < 2; k++) begin
            mHead[k]   = 0;
            mSize[k]   = 0;
            maxExp[k]  = 0;
            popCnt[k]  = 0;
            lastPop[k] = 8'h00;
        end
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_push_pop();
        test_thresholds();
        test_flush();
`ifdef SYNC_FIFO_WMARK_EN
        test_wmark();
`endif
        test_random();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_vr.md
Name: sync_fifo_vr

Overview:
Parametrised successor to the team's generic synchronous FIFO. Single clock domain, valid/ready handshake on both sides, non-power-of-2 depth support, programmable almost-full/almost-empty thresholds, synchronous flush, and an optional registered output stage for timing closure. Used as the standard buffering element between streaming pipeline stages.

Parameters:
DTYPE, logic[7:0], payload type
FIFO_DEPTH, 32, total capacity in words, including the output register when present; integer >= 2, any value
ADDR_WIDTH, $clog2(FIFO_DEPTH), pointer width
OUT_REG, 0, 0 = combinational read from memory; 1 = registered output stage

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of all contents
s_valid  in  1  write request
s_ready  out  1  FIFO can accept a word
s_data  in  DTYPE  write payload
m_valid  out  1  read data valid
m_ready  in  1  consumer accepts the word
m_data  out  DTYPE  read payload
af_thresh  in  ADDR_WIDTH+1  almost-full threshold
ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold
count  out  ADDR_WIDTH+1  words held (memory plus output register)
almost_full  out  1  count >= af_thresh
almost_empty  out  1  count <= ae_thresh

Behaviour:
- Reset (async, rst_n low): pointers = 0, count = 0, output-register valid = 0.
  - Resulting outputs: s_ready = 1, m_valid = 0, almost_empty = (0 <= ae_thresh) = 1; almost_full = 1 only if af_thresh = 0.
  - m_data is don't-care while m_valid = 0. Memory array is not reset.
- Handshake signals:
  - push = s_valid & s_ready.
  - pop = m_valid & m_ready.
  - s_ready = (count != FIFO_DEPTH). There is no write-through when full; a push with a simultaneous pop while full is not accepted.
  - s_ready does not depend on m_ready (no combinational path in to out).
- Pointers:
  - Increment on memory write/read.
  - Wrap from FIFO_DEPTH-1 to 0 explicitly (not by overflow), so non-power-of-2 depths work.
- count:
  - Increments on push only, decrements on pop only.
  - Unchanged on push & pop together, or with neither.
  - Never exceeds FIFO_DEPTH and never underflows.
- OUT_REG = 0:
  - m_valid = (count != 0); m_data = mem[raddr] combinationally.
  - Push-to-m_valid latency: 1 cycle.
- OUT_REG = 1:
  - Output register (ovalid, odata) loads mem[raddr] and advances raddr when (!ovalid | pop) and the memory holds at least one word.
  - m_valid = ovalid; m_data = odata.
  - Push-to-m_valid latency: 2 cycles.
  - Sustained throughput is 1 word/cycle with m_ready held high.
- Flags: almost_full and almost_empty are combinational compares on registered count. Threshold changes take effect in the same cycle.
- Flush: synchronous, highest priority. The next cycle has count = 0, pointers = 0, ovalid = 0. Any push or pop in the flush cycle is discarded, and s_ready is unaffected during flush.
- Reset mid-stream: all contents are lost immediately. Data accepted in the reset cycle is dropped.
- Ordering: strict FIFO order, no reordering or duplication in either mode.

Optional Feature:
- Macro: SYNC_FIFO_WMARK_EN.
- Defined:
  - Adds input wmark_clr (1 bit) and output max_count (ADDR_WIDTH+1 bits).
  - max_count registers the peak count value since reset, flush, or wmark_clr. It updates one cycle after count exceeds it.
  - wmark_clr or flush loads max_count with the current count.
  - max_count resets to 0.
- Undefined: the ports and logic are absent; everything else is unchanged.

Decomposition:
- Package sync_fifo_pkg holds:
  - DEFAULT_DEPTH = 32 and DEFAULT_OUT_REG = 0;
  - struct fifo_status_t {empty, full, almost_empty, almost_full} for monitors and scoreboards.
- Sub-module sync_fifo_out_stage implements the OUT_REG = 1 output register and its load/pop control. It is instantiated via generate when OUT_REG = 1.

Test Plan:
- Setup: depth 5, OUT_REG = 0. Push 5 words 0x10..0x14 with m_ready = 0 -> s_ready drops after the 5th push, count = 5. Then pop all -> data 0x10..0x14 in order, and count returns to 0.
- Setup: depth 5, both OUT_REG values. Run 20 cycles of s_valid = m_ready = 1 with an incrementing payload -> pointers wrap past 4 and no gaps occur after the initial latency. Latency is 1 cycle for OUT_REG = 0 and 2 cycles for OUT_REG = 1.
- Setup: full FIFO. Assert s_valid & m_ready together -> the write is not accepted, one word is popped, count = FIFO_DEPTH-1, and s_ready = 1 next cycle.
- Setup: af_thresh = 3, ae_thresh = 1. Push 3 words -> almost_empty drops at count = 2 and almost_full rises at count = 3. Change af_thresh to 4 -> almost_full falls in the same cycle.
- Setup: 3 words held, OUT_REG = 1. Assert flush together with a push and a pop -> the next cycle shows count = 0 and m_valid = 0. A subsequent push of 0xAA emerges as the first word.
- Setup: SYNC_FIFO_WMARK_EN defined. Fill to 4, drain to 0 -> max_count = 4. Pulse wmark_clr -> max_count = 0. Assert rst_n low mid-stream -> all outputs reach their reset values immediately.
